// File: rtl/uart_rx_word_assembler.sv
// Packs UART receiver byte strobes into words behind a single-entry valid/ready buffer.
// Define UART_WORD_BIG_ENDIAN_EN to place the first received byte in the word's MSB.
module uart_rx_word_assembler #(
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int DATA_W = 8 * BYTES_PER_WORD,
    localparam int CNT_W  = $clog2(BYTES_PER_WORD + 1),
    localparam int GAP_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic [CNT_W-1:0]  byte_cnt_o,
    output logic              overrun_o,
    output logic              timeout_o
);

    // state   | meaning
    // IDLE    | no partial word held, byte count 0
    // COLLECT | partial word held, gap counter running
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [DATA_W-1:0]  asm_q, asm_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic               wvalid_q, wvalid_d;
    logic               ovr_q, ovr_d;
    logic               tmo_q, tmo_d;

    logic               pop;
    logic               can_load;
    logic               last_byte;
    logic               gap_expire;
    logic [DATA_W-1:0]  asm_word;

    function automatic logic [DATA_W-1:0] place_byte(input logic [7:0] b, input logic [CNT_W-1:0] k);
        logic [DATA_W-1:0] w;
        int                sh;
        w = {{(DATA_W-8){1'b0}}, b};
`ifdef UART_WORD_BIG_ENDIAN_EN
        sh = DATA_W - 8 - 8 * int'(k);
`else
        sh = 8 * int'(k);
`endif
        return w << sh;
    endfunction

    assign pop        = wvalid_q & word_ready_i;
    assign can_load   = ~wvalid_q | pop;
    assign last_byte  = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign gap_expire = (gap_q == GAP_W'(TIMEOUT_CYCLES - 2));
    assign asm_word   = asm_q | place_byte(rx_data_i, cnt_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        asm_d    = asm_q;
        word_d   = word_q;
        wvalid_d = wvalid_q & ~pop;
        ovr_d    = ovr_q;
        tmo_d    = 1'b0;

        if (clear_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            gap_d    = '0;
            asm_d    = '0;
            wvalid_d = 1'b0;
            ovr_d    = 1'b0;
        end else if (rx_valid_i) begin
            gap_d = '0;
            if (last_byte) begin
                // A popped buffer can take the new word in the same cycle
                if (can_load) begin
                    word_d   = asm_word;
                    wvalid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
                cnt_d   = '0;
                asm_d   = '0;
                state_d = IDLE;
            end else begin
                asm_d   = asm_word;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = COLLECT;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    gap_d = '0;
                end
                COLLECT: begin
                    if (gap_expire) begin
                        cnt_d   = '0;
                        gap_d   = '0;
                        asm_d   = '0;
                        tmo_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            asm_q    <= '0;
            word_q   <= '0;
            wvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            asm_q    <= asm_d;
            word_q   <= word_d;
            wvalid_q <= wvalid_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = wvalid_q;
    assign byte_cnt_o   = cnt_q;
    assign overrun_o    = ovr_q;
    assign timeout_o    = tmo_q;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Directed bench for uart_rx_word_assembler with a short timeout (10 cycles).
module tb_uart_rx_word_assembler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        clear_i;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i;
    logic [2:0]  byte_cnt_o;
    logic        overrun_o;
    logic        timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_word_assembler #(
        .BYTES_PER_WORD(4),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .clear_i     (clear_i),
        .word_o      (word_o),
        .word_valid_o(word_valid_o),
        .word_ready_i(word_ready_i),
        .byte_cnt_o  (byte_cnt_o),
        .overrun_o   (overrun_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rxv;
        logic [7:0]  d;
        logic        rdy;
        logic        clr;
        logic [31:0] ew;
        logic        ev;
        logic [2:0]  ec;
        logic        eo;
        logic        et;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
`ifdef UART_WORD_BIG_ENDIAN_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    task automatic add(input logic rxv, input logic [7:0] d, input logic rdy, input logic clr,
                       input logic [31:0] ew, input logic ev, input logic [2:0] ec,
                       input logic eo, input logic et);
        vq.push_back('{rxv, d, rdy, clr, ew, ev, ec, eo, et});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ew, input logic ev,
                             input logic [2:0] ec, input logic eo, input logic et);
        chk({tag, " word"},    word_o,              ew);
        chk({tag, " valid"},   32'(word_valid_o),   32'(ev));
        chk({tag, " cnt"},     32'(byte_cnt_o),     32'(ec));
        chk({tag, " overrun"}, 32'(overrun_o),      32'(eo));
        chk({tag, " timeout"}, 32'(timeout_o),      32'(et));
    endtask

    task automatic drive(input logic rxv, input logic [7:0] d, input logic rdy, input logic clr);
        rx_valid_i   = rxv;
        rx_data_i    = d;
        word_ready_i = rdy;
        clear_i      = clr;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] w1, wa, wb, w2;

    initial begin
        rst_n = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0; word_ready_i = 1'b0; clear_i = 1'b0;
        w1 = mk(8'h11, 8'h22, 8'h33, 8'h44);
        wa = mk(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        wb = mk(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        w2 = mk(8'h01, 8'h02, 8'h03, 8'h04);

        // bytes 5 clk apart, consumer always ready
        add(1, 8'h11, 1, 0, 0, 0, 1, 0, 0);
        repeat (4) add(0, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 8'h22, 1, 0, 0, 0, 2, 0, 0);
        repeat (4) add(0, 0, 1, 0, 0, 0, 2, 0, 0);
        add(1, 8'h33, 1, 0, 0, 0, 3, 0, 0);
        repeat (4) add(0, 0, 1, 0, 0, 0, 3, 0, 0);
        add(1, 8'h44, 1, 0, w1, 1, 0, 0, 0);
        add(0, 0, 1, 0, w1, 0, 0, 0, 0);
        // overrun: second word dropped while buffer held
        add(1, 8'hA0, 0, 0, w1, 0, 1, 0, 0);
        add(1, 8'hA1, 0, 0, w1, 0, 2, 0, 0);
        add(1, 8'hA2, 0, 0, w1, 0, 3, 0, 0);
        add(1, 8'hA3, 0, 0, wa, 1, 0, 0, 0);
        add(1, 8'hB0, 0, 0, wa, 1, 1, 0, 0);
        add(1, 8'hB1, 0, 0, wa, 1, 2, 0, 0);
        add(1, 8'hB2, 0, 0, wa, 1, 3, 0, 0);
        add(1, 8'hB3, 0, 0, wa, 1, 0, 1, 0);
        add(0, 0, 1, 0, wa, 0, 0, 1, 0);
        add(0, 0, 0, 1, wa, 0, 0, 0, 0);
        // final byte coincides with pop: no overrun, valid stays high
        add(1, 8'hA0, 0, 0, wa, 0, 1, 0, 0);
        add(1, 8'hA1, 0, 0, wa, 0, 2, 0, 0);
        add(1, 8'hA2, 0, 0, wa, 0, 3, 0, 0);
        add(1, 8'hA3, 0, 0, wa, 1, 0, 0, 0);
        add(1, 8'hB0, 0, 0, wa, 1, 1, 0, 0);
        add(1, 8'hB1, 0, 0, wa, 1, 2, 0, 0);
        add(1, 8'hB2, 0, 0, wa, 1, 3, 0, 0);
        add(1, 8'hB3, 1, 0, wb, 1, 0, 0, 0);
        add(0, 0, 1, 0, wb, 0, 0, 0, 0);
        add(0, 0, 1, 0, wb, 0, 0, 0, 0);

        #12;
        check_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rxv, vq[i].d, vq[i].rdy, vq[i].clr);
            check_all($sformatf("vec%0d", i), vq[i].ew, vq[i].ev, vq[i].ec, vq[i].eo, vq[i].et);
        end

        // timeout after 9 idle cycles
        drive(1, 8'h55, 1, 0);
        drive(1, 8'h66, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 1, 0);
            check_all($sformatf("tmo_idle%0d", i), wb, 0, 2, 0, 0);
        end
        drive(0, 0, 1, 0);
        check_all("tmo_fire", wb, 0, 0, 0, 1);
        drive(0, 0, 1, 0);
        check_all("tmo_after", wb, 0, 0, 0, 0);
        drive(1, 8'h01, 1, 0);
        drive(1, 8'h02, 1, 0);
        drive(1, 8'h03, 1, 0);
        drive(1, 8'h04, 1, 0);
        check_all("tmo_next_word", w2, 1, 0, 0, 0);
        drive(0, 0, 1, 0);
        check_all("tmo_pop", w2, 0, 0, 0, 0);

        // byte arriving on the expiry cycle wins
        drive(1, 8'h55, 1, 0);
        drive(1, 8'h66, 1, 0);
        repeat (8) drive(0, 0, 1, 0);
        drive(1, 8'h77, 1, 0);
        check_all("expiry_byte", w2, 0, 3, 0, 0);
        drive(0, 0, 1, 0);
        check_all("expiry_hold", w2, 0, 3, 0, 0);
        drive(0, 0, 1, 1);
        check_all("expiry_clr", w2, 0, 0, 0, 0);

        // clear with simultaneous byte while valid, overrun and partial word held
        drive(1, 8'hA0, 0, 0); drive(1, 8'hA1, 0, 0); drive(1, 8'hA2, 0, 0); drive(1, 8'hA3, 0, 0);
        drive(1, 8'hB0, 0, 0); drive(1, 8'hB1, 0, 0); drive(1, 8'hB2, 0, 0); drive(1, 8'hB3, 0, 0);
        drive(1, 8'hC0, 0, 0); drive(1, 8'hC1, 0, 0);
        check_all("pre_clear", wa, 1, 2, 1, 0);
        drive(1, 8'hC2, 0, 1);
        check_all("clear", wa, 0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check_all("clear_hold", wa, 0, 0, 0, 0);

        // async reset mid-word
        drive(1, 8'hA0, 0, 0); drive(1, 8'hA1, 0, 0); drive(1, 8'hA2, 0, 0); drive(1, 8'hA3, 0, 0);
        drive(1, 8'h99, 0, 0); drive(1, 8'h98, 0, 0);
        check_all("pre_reset", wa, 1, 2, 0, 0);
        rx_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 8'h01, 1, 0); drive(1, 8'h02, 1, 0); drive(1, 8'h03, 1, 0); drive(1, 8'h04, 1, 0);
        check_all("post_reset_word", w2, 1, 0, 0, 0);
        drive(0, 0, 1, 0);
        check_all("post_reset_pop", w2, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_word_assembler.md
Name: uart_rx_word_assembler

Overview:
Sits directly downstream of the UART receiver FSM and consumes its byte strobes. Packs consecutive received bytes into one 32-bit word, for example for program/data loading into the RISC-V memory. Presents each word over a valid/ready handshake through a single-entry output buffer. Flags partial-word inter-byte timeouts and buffer overruns.

Parameters:
BYTES_PER_WORD, 4, bytes packed per word; output width DATA_W = 8*BYTES_PER_WORD
TIMEOUT_CYCLES, 100000, idle clk cycles allowed between bytes of a partial word before it is discarded; must be >= 2

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
rx_data_i  in  8  received byte from UART receiver
rx_valid_i  in  1  one-cycle strobe, rx_data_i valid this cycle
clear_i  in  1  synchronous flush: drop partial word, empty output buffer, clear overrun_o
word_o  out  DATA_W  assembled word, stable while word_valid_o=1
word_valid_o  out  1  output buffer holds a word
word_ready_i  in  1  consumer accepts word when word_valid_o & word_ready_i
byte_cnt_o  out  $clog2(BYTES_PER_WORD+1)  bytes held in current partial word
overrun_o  out  1  sticky: a completed word was dropped because the buffer was full
timeout_o  out  1  one-cycle pulse: a partial word was discarded on timeout

Behaviour:
- Reset (async, rst_n=0): word_o=0, word_valid_o=0, byte_cnt_o=0, overrun_o=0, timeout_o=0, assembly register=0, gap counter=0.
- FSM states:
  - IDLE: byte_cnt=0.
  - COLLECT: 0<byte_cnt<BYTES_PER_WORD.
  - No separate output state; output buffer valid flag is independent.
- Byte placement: byte k (0-based arrival order) goes to bits [8k+7:8k] (little-endian).
- IDLE + rx_valid_i: store byte 0, byte_cnt=1, go to COLLECT, gap counter=0.
- COLLECT + rx_valid_i, not last byte: store byte, byte_cnt+1, gap counter=0.
- Last byte (byte_cnt=BYTES_PER_WORD-1 and rx_valid_i): the full word, including this byte, is transferred to word_o if the buffer is empty or is being popped this cycle. Set word_valid_o=1 on the next cycle (latency 1 clk from final strobe). byte_cnt=0, go to IDLE.
- Last byte while buffer full and not popped: drop the new word, keep the old word_o unchanged, set overrun_o=1 (sticky until clear_i or reset), byte_cnt=0, go to IDLE.
- Pop: word_valid_o & word_ready_i clears word_valid_o next cycle unless a new word loads in the same cycle, in which case word_valid_o stays 1 with the new word.
- Gap counter:
  - Increments each cycle in COLLECT without rx_valid_i.
  - When it reaches TIMEOUT_CYCLES-1: discard partial word, byte_cnt=0, go to IDLE, pulse timeout_o for 1 cycle.
  - rx_valid_i in the same cycle as expiry: the byte wins and the counter resets, no timeout.
  - Held at 0 in IDLE.
- clear_i has priority over all events except reset:
  - Next cycle: byte_cnt=0, word_valid_o=0, overrun_o=0, timeout_o=0.
  - rx_valid_i in the same cycle is ignored.
- word_ready_i while word_valid_o=0 has no effect.
- Reset mid-word discards all state, with no pulses.

Optional Feature:
UART_WORD_BIG_ENDIAN_EN
- Defined: byte k goes to bits [DATA_W-1-8k : DATA_W-8-8k]; the first byte lands in the MSB.
- Undefined: little-endian placement as above.
- All handshake, timeout and overrun behaviour is identical in both builds.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 strobed 5 clk apart, word_ready_i=1 -> word_o=0x44332211, word_valid_o high 1 clk after the 4th strobe, then low. With UART_WORD_BIG_ENDIAN_EN -> 0x11223344.
- Two full words 0xA0..0xA3 then 0xB0..0xB3, word_ready_i=0 -> word_o stays 0x A3A2A1A0, overrun_o=1. Then ready=1 -> pop, word_valid_o=0.
- Buffer full, final byte of 2nd word arrives in the same cycle as the pop -> no overrun, word_o=0xB3B2B1B0 with valid continuously high.
- TIMEOUT_CYCLES=10: send 0x55, 0x66, then idle -> timeout_o single pulse at 9 idle cycles after 0x66, byte_cnt_o=0. Next 4 bytes 0x01..0x04 -> 0x04030201.
- Byte strobed exactly on the expiry cycle -> no timeout_o, byte_cnt_o increments.
- 2 bytes held, overrun_o=1, word_valid_o=1, assert clear_i with a simultaneous rx_valid_i -> next cycle all flags 0, byte_cnt_o=0, byte ignored. Also: rst_n low mid-word -> all outputs 0 asynchronously.
